// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - op codes, condition codes, flag indices and condition evaluation
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD     = 3'd0,
        OP_INC      = 3'd1,
        OP_BRANCH   = 3'd2,
        OP_JUMP     = 3'd3,
        OP_JUMP_REG = 3'd4,
        OP_CALL     = 3'd5,
        OP_RET      = 3'd6,
        OP_RSVD     = 3'd7
    } pcOpE;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_HI = 4'd4,
        COND_LS = 4'd5,
        COND_GT = 4'd6,
        COND_LE = 4'd7,
        COND_FS = 4'd8,
        COND_FC = 4'd9,
        COND_LO = 4'd10,
        COND_HS = 4'd11,
        COND_LT = 4'd12,
        COND_GE = 4'd13,
        COND_UC = 4'd14,
        COND_NV = 4'd15
    } pcCondE;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Shared by the PC unit and any instruction decoder that needs the same predicate.
    function automatic logic evalCond(input logic [3:0] cond, input logic [4:0] flags);
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
        logic result;
        c = flags[FLAG_C];
        l = flags[FLAG_L];
        f = flags[FLAG_F];
        z = flags[FLAG_Z];
        n = flags[FLAG_N];
        result = 1'b0;
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = !z;
            COND_CS: result = c;
            COND_CC: result = !c;
            COND_HI: result = l;
            COND_LS: result = !l;
            COND_GT: result = n;
            COND_LE: result = !n;
            COND_FS: result = f;
            COND_FC: result = !f;
            COND_LO: result = !l && !z;
            COND_HS: result = l || z;
            COND_LT: result = !n && !z;
            COND_GE: result = n || z;
            COND_UC: result = 1'b1;
            COND_NV: result = 1'b0;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - LIFO return-address stack
// Ports: clk, reset (sync, active-low), push/pop requests, pushData in,
//        top (0 when empty), count, full, empty.
// A push while full or a pop while empty is ignored here; the caller flags it.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          pushData,
    output logic [WIDTH-1:0]          top,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE = 1;

    logic [WIDTH-1:0] stackMem [DEPTH];
    logic [PTR_W-1:0] topIdx;

    // When full the low count bits wrap to 0, so subtracting one still lands on DEPTH-1.
    assign topIdx = count[PTR_W-1:0] - IDX_ONE;
    assign full   = (count == CNT_MAX);
    assign empty  = (count == '0);
    assign top    = empty ? '0 : stackMem[topIdx];

    // Storage carries no reset; clearing the count is enough to empty the stack.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            stackMem[count[PTR_W-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_ONE;
        end else if (pop && !empty) begin
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with conditional branches and call/return stack
// Ports: clk, reset (sync, active-low), stall, op[2:0], cond[3:0], flags[4:0]
//        (C,L,F,Z,N from bit 0), imm, r_target in; pc_out, link_out (stack top or 0),
//        stack_count, sticky overflow/underflow out.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int                WIDTH      = 16,
    parameter int                DEPTH      = 8,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [2:0]                op,
    input  logic [3:0]                cond,
    input  logic [4:0]                flags,
    input  logic [WIDTH-1:0]          imm,
    input  logic [WIDTH-1:0]          r_target,
    output logic [WIDTH-1:0]          pc_out,
    output logic [WIDTH-1:0]          link_out,
    output logic [$clog2(DEPTH):0]    stack_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam logic [WIDTH-1:0] PC_ONE = 1;

    logic [WIDTH-1:0] pcInc;
    logic [WIDTH-1:0] pcNext;
    logic [WIDTH-1:0] stackTop;
    logic             condTrue;
    logic             doPush;
    logic             doPop;
    logic             setOverflow;
    logic             setUnderflow;
    logic             stackFull;
    logic             stackEmpty;

    assign pcInc    = pc_out + PC_ONE;
    assign condTrue = evalCond(cond, flags);
    assign link_out = stackTop;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (doPush),
        .pop      (doPop),
        .pushData (pcInc),
        .top      (stackTop),
        .count    (stack_count),
        .full     (stackFull),
        .empty    (stackEmpty)
    );

    always_comb begin
        pcNext       = pc_out;
        doPush       = 1'b0;
        doPop        = 1'b0;
        setOverflow  = 1'b0;
        setUnderflow = 1'b0;
        if (!stall) begin
            case (op)
                OP_INC:      pcNext = pcInc;
                OP_BRANCH:   pcNext = condTrue ? (pc_out + imm) : pcInc;
                OP_JUMP:     pcNext = condTrue ? imm : pcInc;
                OP_JUMP_REG: pcNext = condTrue ? r_target : pcInc;
                OP_CALL: begin
                    // The jump happens even when the push has to be dropped.
                    pcNext = imm;
                    if (stackFull) begin
                        setOverflow = 1'b1;
                    end else begin
                        doPush = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stackEmpty) begin
                        pcNext       = pcInc;
                        setUnderflow = 1'b1;
                    end else begin
                        pcNext = stackTop;
                        doPop  = 1'b1;
                    end
                end
                default: pcNext = pc_out;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_out    <= RESET_ADDR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc_out    <= pcNext;
            overflow  <= overflow | setOverflow;
            underflow <= underflow | setUnderflow;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - scoreboard bench for pc_stack_unit against a queue-based model
module tb_pc_stack_unit;

    localparam int OPH = 0, OPI = 1, OPB = 2, OPJ = 3, OPJR = 4, OPC = 5, OPR = 6;
    localparam int CEQ = 0, CUC = 14;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  op;
    logic [3:0]  cond;
    logic [4:0]  flags;
    logic [15:0] imm;
    logic [15:0] r_target;
    logic [15:0] pc_out;
    logic [15:0] link_out;
    logic [3:0]  stack_count;
    logic        overflow;
    logic        underflow;

    pc_stack_unit #(
        .WIDTH      (16),
        .DEPTH      (8),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .op          (op),
        .cond        (cond),
        .flags       (flags),
        .imm         (imm),
        .r_target    (r_target),
        .pc_out      (pc_out),
        .link_out    (link_out),
        .stack_count (stack_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] link;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } expT;

    expT   expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state
    logic [15:0] mPc;
    logic [15:0] mStack[$];
    bit          mOvf;
    bit          mUnf;

    function automatic bit condModel(input int c, input logic [4:0] f);
        bit fc, fl, ff, fz, fn;
        bit t[16];
        fc = f[0]; fl = f[1]; ff = f[2]; fz = f[3]; fn = f[4];
        t = '{fz, !fz, fc, !fc, fl, !fl, fn, !fn, ff, !ff,
              !fl && !fz, fl || fz, !fn && !fz, fn || fz, 1'b1, 1'b0};
        return t[c];
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    // Applies one cycle of stimulus and queues the state the model says should follow.
    task automatic drive(input bit rst, input bit stl, input int o, input int c,
                         input logic [4:0] f, input logic [15:0] im,
                         input logic [15:0] rt, input string nm);
        expT e;
        @(negedge clk);
        reset = rst; stall = stl; op = 3'(o); cond = 4'(c);
        flags = f; imm = im; r_target = rt;
        if (!rst) begin
            mPc = 16'h0000;
            mStack.delete();
            mOvf = 0;
            mUnf = 0;
        end else if (!stl) begin
            case (o)
                OPI:  mPc = mPc + 16'd1;
                OPB:  mPc = condModel(c, f) ? mPc + im : mPc + 16'd1;
                OPJ:  mPc = condModel(c, f) ? im : mPc + 16'd1;
                OPJR: mPc = condModel(c, f) ? rt : mPc + 16'd1;
                OPC: begin
                    if (mStack.size() == 8) mOvf = 1;
                    else mStack.push_back(mPc + 16'd1);
                    mPc = im;
                end
                OPR: begin
                    if (mStack.size() == 0) begin
                        mPc = mPc + 16'd1;
                        mUnf = 1;
                    end else begin
                        mPc = mStack.pop_back();
                    end
                end
                default: ;
            endcase
        end
        e.pc   = mPc;
        e.link = (mStack.size() > 0) ? mStack[$] : 16'h0000;
        e.cnt  = 4'(mStack.size());
        e.ovf  = mOvf;
        e.unf  = mUnf;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    task automatic doOp(input int o, input int c, input logic [4:0] f,
                        input logic [15:0] im, input string nm);
        drive(1, 0, o, c, f, im, 16'h0000, nm);
    endtask

    // Monitor: the DUT presents a fresh state every cycle; compare just after the edge.
    initial begin
        expT   e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                check({nm, ".pc"},    pc_out,               e.pc);
                check({nm, ".link"},  link_out,             e.link);
                check({nm, ".count"}, {12'h0, stack_count}, {12'h0, e.cnt});
                check({nm, ".ovf"},   {15'h0, overflow},    {15'h0, e.ovf});
                check({nm, ".unf"},   {15'h0, underflow},   {15'h0, e.unf});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0; stall = 0; op = 0; cond = 0; flags = 0; imm = 0; r_target = 0;
        mPc = 0; mOvf = 0; mUnf = 0;

        // Reset, three increments, then stall holds
        drive(0, 0, OPH, 0, 5'h0, 16'h0, 16'h0, "reset");
        for (int i = 0; i < 3; i++) doOp(OPI, 0, 5'h0, 16'h0, "inc");
        drive(1, 1, OPI, 0, 5'h0, 16'h0, 16'h0, "stall_inc");
        drive(1, 1, OPC, 0, 5'h0, 16'h55, 16'h0, "stall_call");

        // Backward branch taken, then not taken
        doOp(OPJ, CUC, 5'h0, 16'd10, "set10");
        doOp(OPB, CEQ, 5'h08, 16'hFFFE, "br_eq_z1");
        doOp(OPB, CEQ, 5'h00, 16'hFFFE, "br_eq_z0");

        // Call and return
        doOp(OPJ, CUC, 5'h0, 16'd5, "set5");
        doOp(OPC, 7, 5'h0, 16'h40, "call");
        doOp(OPR, 0, 5'h0, 16'h0, "ret");

        // Fill past depth, then unwind
        for (int i = 0; i < 9; i++) doOp(OPC, 0, 5'h0, 16'h200 + 16'(i * 3), "call_fill");
        for (int i = 0; i < 8; i++) doOp(OPR, 0, 5'h0, 16'h0, "ret_unwind");

        // Underflow then reset clears flags
        doOp(OPJ, CUC, 5'h0, 16'h20, "set20");
        doOp(OPR, 0, 5'h0, 16'h0, "ret_empty");
        drive(0, 1, OPC, 0, 5'h0, 16'h77, 16'h0, "reset_over_call");
        doOp(OPC, 0, 5'h0, 16'h300, "call_after_rst");
        drive(0, 0, OPR, 0, 5'h0, 16'h0, 16'h0, "reset_over_ret");

        // Full condition sweep with JUMP to 0x100
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                doOp(OPJ, CUC, 5'h0, 16'($urandom_range(0, 16'hFFFF)), "sweep_set");
                doOp(OPJ, c, 5'(f), 16'h100, "sweep_jump");
            end
        end

        // Randomized traffic, including stalls, resets and JUMP_REG
        drive(0, 0, OPH, 0, 5'h0, 16'h0, 16'h0, "rand_reset");
        for (int i = 0; i < 2000; i++) begin
            bit rst;
            bit stl;
            rst = ($urandom_range(0, 99) != 0);
            stl = ($urandom_range(0, 9) == 0);
            drive(rst, stl, $urandom_range(0, 7), $urandom_range(0, 15),
                  5'($urandom_range(0, 31)), 16'($urandom_range(0, 16'hFFFF)),
                  16'($urandom_range(0, 16'hFFFF)), "random");
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter WIDTH, default 16: address, immediate and target width.
REQ-002 Parameter DEPTH, default 8: return-stack entries; a power of two, at least 2.
REQ-003 Parameter RESET_ADDR, default 0: PC value after reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low.
REQ-006 stall  in  1  when high, all state is frozen and op is ignored.
REQ-007 op  in  3  0 HOLD, 1 INC, 2 BRANCH, 3 JUMP, 4 JUMP_REG, 5 CALL, 6 RET, 7 reserved.
REQ-008 cond  in  4  EQ,NE,CS,CC,HI,LS,GT,LE,FS,FC,LO,HS,LT,GE,UC,NV, encoded 0..15.
REQ-009 flags  in  5  bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
REQ-010 imm  in  WIDTH  relative offset (BRANCH) or absolute target (JUMP, CALL).
REQ-011 r_target  in  WIDTH  register target (JUMP_REG).
REQ-012 pc_out  out  WIDTH  current PC, driven directly from the register.
REQ-013 link_out  out  WIDTH  top-of-stack value; 0 when the stack is empty.
REQ-014 stack_count  out  clog2(DEPTH)+1  number of occupied entries.
REQ-015 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 Condition truth table:
- EQ=Z, NE=!Z, CS=C, CC=!C, HI=L, LS=!L.
- GT=N, LE=!N, FS=F, FC=!F.
- LO=!L&!Z, HS=L|Z, LT=!N&!Z, GE=N|Z.
- UC=1, NV=0.
REQ-017 HOLD and reserved op: pc_out is unchanged.
REQ-018 INC: pc_out <= pc_out+1.
REQ-019 BRANCH: pc_out <= pc_out+imm if cond is true, else pc_out+1.
REQ-020 JUMP: pc_out <= imm if cond is true, else pc_out+1.
REQ-021 JUMP_REG: pc_out <= r_target if cond is true, else pc_out+1.
REQ-022 CALL: unconditional; pushes pc_out+1 and sets pc_out <= imm; cond is ignored.
REQ-023 RET: unconditional; pops the top entry into pc_out.
REQ-024 All address arithmetic is modulo 2^WIDTH; wrap-around is silent.
REQ-025 Every op takes effect one clock after sampling; the new pc_out is visible the cycle after the edge.
REQ-026 CALL when stack_count==DEPTH: the push is dropped, pc_out <= imm, overflow is set, and stack contents are unchanged.
REQ-027 RET when stack_count==0: pc_out <= pc_out+1, underflow is set, and the count stays 0.
REQ-028 overflow and underflow remain set until reset.
REQ-029 stall high: pc_out, the stack, the count and the flags are all held; stall overrides op.
REQ-030 Stack updates are LIFO; link_out reflects the new top the cycle after a push or pop.

Reset
REQ-031 reset low at a clock edge sets:
- pc_out to RESET_ADDR;
- stack_count to 0 (stack emptied);
- link_out to 0;
- overflow and underflow to 0.
REQ-032 Reset overrides stall and op, including mid-CALL or mid-RET.
REQ-033 Storage contents need no reset; only the count is cleared.

Structure
REQ-034 Shared package pc_pkg holds the op codes, condition codes and flag bit-index constants.
REQ-035 Condition evaluation is a function in pc_pkg, so the decoder can reuse it.
REQ-036 The return stack is sub-module pc_return_stack, parametrised by WIDTH and DEPTH, with push, pop, top, count, full and empty.

Verification
REQ-037 Reset, then 3 INC -> pc_out = 3; stall high with INC for 2 cycles -> pc_out stays 3.
REQ-038 pc_out=10, BRANCH, imm=0xFFFE, cond=EQ:
- with Z=1 -> pc_out = 8;
- repeated with Z=0 -> pc_out = 9.
REQ-039 pc_out=5, CALL imm=0x40 -> pc_out = 0x40, link_out = 6, count = 1; then RET -> pc_out = 6, count = 0, link_out = 0.
REQ-040 DEPTH=8: 9 consecutive CALLs -> count = 8, overflow = 1, pc_out = imm; then 8 RETs return the first 8 link values in reverse order.
REQ-041 RET on empty stack at pc_out=0x20 -> pc_out = 0x21, underflow = 1; a reset pulse clears both flags and pc_out = RESET_ADDR.
REQ-042 Sweep all 16 cond values × 32 flag patterns with JUMP imm=0x100 -> each result is 0x100 or pc_out+1, per REQ-016.
